// File: rtl/part_update.sv
// ---------------------------------------------------------------------------
// part_update
//
// Downstream stage of the graph-partitioning worker. Takes one batch of Q
// per-vertex results (vertex id, proposed partition, gain, current partition)
// and walks the lanes one per cycle in lane order. A lane's move is accepted
// when it actually changes partition, its gain reaches PRO_TH, the
// destination is below CAP and the source is non-empty. Accepted moves are
// written back to the location SRAM, one lane per cycle. The K partition-size
// counters are updated as each move is accepted, so later lanes and later
// batches see the new sizes.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid_i          a batch is present on the input buses
//   in_ready_o          block is idle and can accept a batch
//   batch_num_i         tag of the incoming batch
//   vid_in_i            Q vertex ids, lane i at [i*VID_BW +: VID_BW]
//   next_in_i           Q proposed partitions
//   pro_in_i            Q unsigned gains
//   cur_in_i            Q current partitions
//   loc_we_o            location SRAM write strobe
//   loc_waddr_o         SRAM row (upper vertex id bits)
//   loc_wlane_o         lane within the row (lower vertex id bits)
//   loc_wdata_o         {valid=1, new partition}
//   batch_done_o        one-cycle pulse when a batch has finished
//   done_batch_num_o    tag of the last finished batch
//   moves_o             accepted moves in the last finished batch
//   cnt_sel_i           debug counter select
//   cnt_rdata_o         combinational read of the selected counter
// ---------------------------------------------------------------------------
module part_update #(
  parameter int K              = 16,
  parameter int Q              = 16,
  parameter int NEXT_BW        = 4,
  parameter int PRO_BW         = 8,
  parameter int VID_BW         = 16,
  parameter int D              = 256,
  parameter int LOC_BW         = 5,
  parameter int LOC_ADDR_SPACE = 8,
  parameter int N_VERT         = 4096,
  parameter int CAP            = 272,
  parameter logic [PRO_BW-1:0] PRO_TH = 8'd4,
  parameter int BATCH_BW       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [BATCH_BW-1:0]       batch_num_i,
  input  logic [Q*VID_BW-1:0]       vid_in_i,
  input  logic [Q*NEXT_BW-1:0]      next_in_i,
  input  logic [Q*PRO_BW-1:0]       pro_in_i,
  input  logic [Q*NEXT_BW-1:0]      cur_in_i,
  output logic                      loc_we_o,
  output logic [LOC_ADDR_SPACE-1:0] loc_waddr_o,
  output logic [$clog2(D)-1:0]      loc_wlane_o,
  output logic [LOC_BW-1:0]         loc_wdata_o,
  output logic                      batch_done_o,
  output logic [BATCH_BW-1:0]       done_batch_num_o,
  output logic [$clog2(Q+1)-1:0]    moves_o,
  input  logic [NEXT_BW-1:0]        cnt_sel_i,
  output logic [9:0]                cnt_rdata_o
);

  localparam int CNT_BW   = 10;
  localparam int IDX_BW   = $clog2(Q);
  localparam int LANE_BW  = $clog2(D);
  localparam int TALLY_BW = $clog2(Q+1);

  localparam logic [CNT_BW-1:0] CNT_INIT = CNT_BW'(N_VERT / K);
  localparam logic [CNT_BW-1:0] CNT_CAP  = CNT_BW'(CAP);
  localparam logic [IDX_BW-1:0] IDX_LAST = IDX_BW'(Q - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PROC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_BW-1:0]     idx_q, idx_d;
  logic [TALLY_BW-1:0]   tally_q, tally_d;

  logic [Q*VID_BW-1:0]   vid_q;
  logic [Q*NEXT_BW-1:0]  next_q;
  logic [Q*PRO_BW-1:0]   pro_q;
  logic [Q*NEXT_BW-1:0]  cur_q;
  logic [BATCH_BW-1:0]   batch_q;

  logic [CNT_BW-1:0]     cnt_q [K];

  logic                      loc_we_q;
  logic [LOC_ADDR_SPACE-1:0] loc_waddr_q;
  logic [LANE_BW-1:0]        loc_wlane_q;
  logic [LOC_BW-1:0]         loc_wdata_q;
  logic [TALLY_BW-1:0]       moves_q;
  logic [BATCH_BW-1:0]       done_num_q;

  logic [VID_BW-1:0]  lane_vid;
  logic [NEXT_BW-1:0] lane_next;
  logic [NEXT_BW-1:0] lane_cur;
  logic [PRO_BW-1:0]  lane_pro;
  logic [CNT_BW-1:0]  cnt_next;
  logic [CNT_BW-1:0]  cnt_cur;
  logic               accept;
  logic               take_batch;
  logic               last_lane;

  assign take_batch = (state_q == S_IDLE) && in_valid_i;
  assign last_lane  = (state_q == S_PROC) && (idx_q == IDX_LAST);

  assign lane_vid  = vid_q[idx_q*VID_BW +: VID_BW];
  assign lane_next = next_q[idx_q*NEXT_BW +: NEXT_BW];
  assign lane_cur  = cur_q[idx_q*NEXT_BW +: NEXT_BW];
  assign lane_pro  = pro_q[idx_q*PRO_BW +: PRO_BW];

  // The counters read here already include every earlier lane of this
  // batch, which is what makes capacity races resolve in lane order.
  assign cnt_next = cnt_q[lane_next];
  assign cnt_cur  = cnt_q[lane_cur];

  assign accept = (state_q == S_PROC) &&
                  (lane_next != lane_cur) &&
                  (lane_pro >= PRO_TH) &&
                  (cnt_next < CNT_CAP) &&
                  (cnt_cur != '0);

  // Next-state logic: IDLE waits for a batch, PROC steps one lane per cycle,
  // DONE is a single reporting cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tally_d = tally_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d = S_PROC;
          idx_d   = '0;
          tally_d = '0;
        end
      end
      S_PROC: begin
        idx_d = idx_q + 1'b1;
        if (accept) begin
          tally_d = tally_q + 1'b1;
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tally_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tally_q <= tally_d;
    end
  end

  // Batch capture; the source may change the buses once the batch is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_q   <= '0;
      next_q  <= '0;
      pro_q   <= '0;
      cur_q   <= '0;
      batch_q <= '0;
    end else if (take_batch) begin
      vid_q   <= vid_in_i;
      next_q  <= next_in_i;
      pro_q   <= pro_in_i;
      cur_q   <= cur_in_i;
      batch_q <= batch_num_i;
    end
  end

  // Partition-size counters. next and cur are distinct on accept, so the
  // two updates never target the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < K; k++) begin
        cnt_q[k] <= CNT_INIT;
      end
    end else if (accept) begin
      cnt_q[lane_next] <= cnt_next + CNT_BW'(1);
      cnt_q[lane_cur]  <= cnt_cur - CNT_BW'(1);
    end
  end

  // Registered single-lane SRAM write, one cycle behind the evaluating lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_we_q    <= 1'b0;
      loc_waddr_q <= '0;
      loc_wlane_q <= '0;
      loc_wdata_q <= '0;
    end else begin
      loc_we_q <= accept;
      if (accept) begin
        loc_waddr_q <= lane_vid[VID_BW-1 -: LOC_ADDR_SPACE];
        loc_wlane_q <= lane_vid[LANE_BW-1:0];
        loc_wdata_q <= {1'b1, lane_next};
      end
    end
  end

  // Batch results are captured with the last lane's contribution included
  // and then held until the following batch finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moves_q    <= '0;
      done_num_q <= '0;
    end else if (last_lane) begin
      moves_q    <= tally_d;
      done_num_q <= batch_q;
    end
  end

  assign in_ready_o       = (state_q == S_IDLE);
  assign batch_done_o     = (state_q == S_DONE);
  assign loc_we_o         = loc_we_q;
  assign loc_waddr_o      = loc_waddr_q;
  assign loc_wlane_o      = loc_wlane_q;
  assign loc_wdata_o      = loc_wdata_q;
  assign moves_o          = moves_q;
  assign done_batch_num_o = done_num_q;
  assign cnt_rdata_o      = cnt_q[cnt_sel_i];

endmodule
